l2c_mem_arbiter: RTL

Memory-side request arbiter and burst sequencer for the L2 cache. It consumes the level-held writeback (dirty) and refill (replace) requests issued by the L2 cache controller for the instruction and data channels. It runs one line-sized burst at a time on the L2 memory port and returns one-cycle done pulses that advance the controller state machines. It sits between the L2 cache controller and the external memory/bus interface, in the clk_l2 domain.

---
 rtl/l2c_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/l2c_mem_arbiter.sv
// L2 memory-side arbiter: round-robin inst/data, dirty-first, one line burst at a time.
// Optional ack watchdog and sticky mem_err when L2C_MEM_TIMEOUT_EN is defined.
module l2c_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_WORDS  = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk_l2,
    input  logic                          rst_n,
    input  logic                          inst_mem_dirty_req,
    input  logic                          inst_mem_replace_req,
    input  logic                          data_mem_dirty_req,
    input  logic                          data_mem_replace_req,
    input  logic [ADDR_W-1:0]             inst_wb_addr,
    input  logic [ADDR_W-1:0]             inst_rf_addr,
    input  logic [ADDR_W-1:0]             data_wb_addr,
    input  logic [ADDR_W-1:0]             data_rf_addr,
    output logic                          inst_mem_dirty_done,
    output logic                          inst_mem_replace_done,
    output logic                          data_mem_dirty_done,
    output logic                          data_mem_replace_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    output logic [$clog2(LINE_WORDS)-1:0] mem_beat,
    output logic                          l2_fill_wr,
    output logic                          src_data
`ifdef L2C_MEM_TIMEOUT_EN
    ,
    output logic                          mem_err
`endif
);

    localparam int BEAT_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DONE} state_t;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat, beat_nxt;
    logic                last_grant;
    logic                inst_any, data_any, any_req;
    logic                grant_data, grant_dirty;
    logic [ADDR_W-1:0]   grant_addr;
    logic                wd_hit;

    assign inst_any    = inst_mem_dirty_req | inst_mem_replace_req;
    assign data_any    = data_mem_dirty_req | data_mem_replace_req;
    assign any_req     = inst_any | data_any;
    // With both channels requesting, the one that did not complete last wins
    assign grant_data  = data_any & (~inst_any | ~last_grant);
    assign grant_dirty = grant_data ? data_mem_dirty_req : inst_mem_dirty_req;
    assign grant_addr  = grant_data ? (grant_dirty ? data_wb_addr : data_rf_addr)
                                    : (grant_dirty ? inst_wb_addr : inst_rf_addr);

`ifdef L2C_MEM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_hit = mem_req & ~mem_ack & (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            if (!mem_req || mem_ack || wd_hit)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_hit)
                mem_err <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        unique case (state)
            IDLE: if (any_req) state_nxt = ISSUE;
            ISSUE, BURST: begin
                if (mem_ack) begin
                    if (beat == BEAT_W'(LINE_WORDS - 1)) begin
                        state_nxt = DONE;
                        beat_nxt  = '0;
                    end else begin
                        state_nxt = BURST;
                        beat_nxt  = beat + BEAT_W'(1);
                    end
                end else if (wd_hit) begin
                    state_nxt = DONE;
                    beat_nxt  = '0;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            src_data   <= 1'b0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (state == IDLE && any_req) begin
                mem_addr <= grant_addr;
                mem_we   <= grant_dirty;
                src_data <= grant_data;
            end
            if (state == DONE)
                last_grant <= src_data;
        end
    end

    assign mem_req               = (state == ISSUE) | (state == BURST);
    assign mem_beat              = beat;
    assign l2_fill_wr            = mem_req & ~mem_we & mem_ack;
    assign inst_mem_dirty_done   = (state == DONE) & ~src_data &  mem_we;
    assign inst_mem_replace_done = (state == DONE) & ~src_data & ~mem_we;
    assign data_mem_dirty_done   = (state == DONE) &  src_data &  mem_we;
    assign data_mem_replace_done = (state == DONE) &  src_data & ~mem_we;

endmodule
